// File: rtl/aes_round_engine.sv
// Iterative AES encryptor with one key-schedule word or one cipher round per clock and a one-entry expanded-key cache.
// Optional macro AES_ROUND_OUT_EN adds output round_o showing the current round index.

module aes_round_engine #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic [127:0]        data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
`ifdef AES_ROUND_OUT_EN
    ,
    output logic [3:0]          round_o
`endif
);

    localparam int unsigned NK   = KEY_BITS / 32;
    localparam int unsigned NR   = NK + 6;
    localparam int unsigned NW   = 4 * (NR + 1);
    localparam int unsigned WI_W = 6;
    localparam int unsigned RC_W = 4;
    localparam int unsigned KM_W = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] KEXP  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse computed as a^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        inv  = gf_mul(gf_mul(a240, a12), a2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = sbox(s[8*n +: 8]);
        return r;
    endfunction

    // Byte n = 4*col + row sits at bits [127-8n -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                r[127-8*(4*c+b) -: 8] = s[127-8*(4*((c+b)%4)+b) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [31:0]  col;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            a0  = col[31:24];
            a1  = col[23:16];
            a2  = col[15:8];
            a3  = col[7:0];
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    logic [1:0]           state, state_nxt;
    logic [NW-1:0][31:0]  w_q;
    logic [WI_W-1:0]      widx;
    logic [KM_W-1:0]      kmod;
    logic [7:0]           rcon;
    logic [RC_W-1:0]      round_cnt, round_cnt_nxt;
    logic [127:0]         st;
    logic [KEY_BITS-1:0]  key_q, cache_key;
    logic                 cache_vld;
    logic                 accept, hit, kexp_last, round_last;
    logic [31:0]          w_prev, w_far, w_tmp, w_new;
    logic [WI_W-1:0]      rk_base;
    logic [127:0]         rk, sr, mc, round_res;
    logic                 in_ready_nxt, out_valid_nxt, busy_nxt;

    assign accept     = in_valid & in_ready;
    assign hit        = cache_vld && (key == cache_key);
    assign kexp_last  = (widx == WI_W'(NW - 1));
    assign round_last = (round_cnt == RC_W'(NR));

    // Next key-schedule word W[widx].
    always_comb begin
        w_prev = w_q[widx - WI_W'(1)];
        w_far  = w_q[widx - WI_W'(NK)];
        w_tmp  = w_prev;
        if (kmod == '0) begin
            w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h000000};
        end else if (NK == 8 && kmod == KM_W'(4)) begin
            w_tmp = sub_word(w_prev);
        end
        w_new = w_far ^ w_tmp;
    end

    // One cipher round; round 0 is key whitening, the last round skips MixColumns.
    always_comb begin
        rk_base   = {round_cnt, 2'b00};
        rk        = {w_q[rk_base], w_q[rk_base + WI_W'(1)],
                     w_q[rk_base + WI_W'(2)], w_q[rk_base + WI_W'(3)]};
        sr        = shift_rows(sub_bytes(st));
        mc        = mix_columns(sr);
        round_res = mc ^ rk;
        if (round_cnt == '0) begin
            round_res = st ^ rk;
        end else if (round_last) begin
            round_res = sr ^ rk;
        end
    end

    always_comb begin
        state_nxt     = state;
        round_cnt_nxt = round_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = hit ? ROUND : KEXP;
                    round_cnt_nxt = '0;
                end
            end
            KEXP: begin
                if (kexp_last) begin
                    state_nxt     = ROUND;
                    round_cnt_nxt = '0;
                end
            end
            ROUND: begin
                if (round_last) state_nxt = DONE;
                else            round_cnt_nxt = round_cnt + RC_W'(1);
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            cache_vld <= 1'b0;
            round_cnt <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            round_cnt <= round_cnt_nxt;
            if (state == KEXP && kexp_last) cache_vld <= 1'b1;
            if (state == ROUND && round_last) out_data <= round_res;
        end
    end

    // Datapath: cached schedule survives in w_q between requests with the same key.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                st    <= data;
                key_q <= key;
                widx  <= WI_W'(NK);
                kmod  <= '0;
                rcon  <= 8'h01;
                if (!hit) begin
                    for (int j = 0; j < NK; j++) w_q[j] <= key[KEY_BITS-1-32*j -: 32];
                end
            end
            if (state == KEXP) begin
                w_q[widx] <= w_new;
                widx      <= widx + WI_W'(1);
                kmod      <= (kmod == KM_W'(NK - 1)) ? '0 : kmod + KM_W'(1);
                if (kmod == '0) rcon <= xtime(rcon);
                if (kexp_last) cache_key <= key_q;
            end
            if (state == ROUND) st <= round_res;
        end
    end

`ifdef AES_ROUND_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) round_o <= '0;
        else     round_o <= (state_nxt == ROUND) ? round_cnt_nxt : '0;
    end
`endif

endmodule
